// File: rtl/dmem_dump_tx.sv
// Reads a range of data-memory words on a second read port and streams
// each word off-chip as four UART 8N1 frames, least-significant byte first.
module dmem_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_FINISH
  } state_t;

  localparam logic [15:0]      LP_TC      = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;

  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_remaining;
  logic [31:0]      r_word;
  logic [7:0]       r_shift;
  logic [15:0]      r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [1:0]       r_byte_idx;

  logic             w_tick;
  logic             w_last_byte;
  logic             w_last_word;
  logic [7:0]       w_byte;

  assign w_tick      = (r_clk_cnt == LP_TC);
  assign w_last_byte = (r_byte_idx == 2'd3);
  // Remaining is at least one while transmitting, so "minus one is zero" is "equals one".
  assign w_last_word = (r_remaining == LP_CNT_ONE);

  always_comb begin
    w_byte = r_word[7:0];
    case (r_byte_idx)
      2'd0: w_byte = r_word[7:0];
      2'd1: w_byte = r_word[15:8];
      2'd2: w_byte = r_word[23:16];
      2'd3: w_byte = r_word[31:24];
      default: w_byte = r_word[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    tx       = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    mem_addr = r_addr;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        mem_addr = '0;
        if (start) begin
          w_next = (word_count == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_START_BIT;
      end
      S_START_BIT: begin
        tx = 1'b0;
        if (w_tick) begin
          w_next = S_DATA_BITS;
        end
      end
      S_DATA_BITS: begin
        tx = r_shift[0];
        if (w_tick && (r_bit_cnt == 3'd7)) begin
          w_next = S_STOP_BIT;
        end
      end
      S_STOP_BIT: begin
        if (w_tick) begin
          if (!w_last_byte) begin
            w_next = S_START_BIT;
          end else if (w_last_word) begin
            w_next = S_FINISH;
          end else begin
            w_next = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        busy   = 1'b0;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_shift     <= '0;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_byte_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
          end
        end
        S_FETCH: begin
          r_word     <= mem_rdata;
          r_byte_idx <= '0;
          r_clk_cnt  <= '0;
        end
        S_START_BIT: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= w_byte;
            r_bit_cnt <= '0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_DATA_BITS: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_STOP_BIT: begin
          if (w_tick) begin
            r_clk_cnt <= '0;
            if (!w_last_byte) begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end else begin
              r_remaining <= r_remaining - LP_CNT_ONE;
              r_addr      <= r_addr + 32'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_FINISH: begin
          r_clk_cnt <= '0;
        end
        default: begin
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_tx.sv
// Directed bench for dmem_dump_tx: records each dump cycle by cycle and
// decodes the UART frames against hand-computed bytes and cycle numbers.
module tb_dmem_dump_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  word_count;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  logic        tx_t   [0:1023];
  logic        busy_t [0:1023];
  logic        done_t [0:1023];
  logic [31:0] addr_t [0:1023];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[3:0]];

  dmem_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start accepted at edge 0; returns positioned in cycle 1.
  task automatic launch(input logic [31:0] b, input logic [7:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic capture(input int n, input bit poke, input int mod_cyc,
                         input int mod_idx, input logic [31:0] mod_val);
    for (int c = 1; c <= n; c++) begin
      tx_t[c]   = tx;
      busy_t[c] = busy;
      done_t[c] = done;
      addr_t[c] = mem_addr;
      start     = poke && (c % 37 == 0) && (c < 300);
      if (c == mod_cyc) mem[mod_idx] = mod_val;
      step();
    end
    start = 1'b0;
  endtask

  task automatic check_byte(input string tag, input int s, input logic [7:0] exp);
    logic [7:0] d;
    chkb({tag, "_start"}, tx_t[s + CPB/2], 1'b0);
    for (int i = 0; i < 8; i++) d[i] = tx_t[s + CPB*(i+1) + CPB/2];
    chk(tag, {24'h0, d}, {24'h0, exp});
    chkb({tag, "_stop"}, tx_t[s + 9*CPB + CPB/2], 1'b1);
  endtask

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (done_t[c]) n++;
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (busy_t[c]) n++;
    return n;
  endfunction

  function automatic int count_txlow(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (!tx_t[c]) n++;
    return n;
  endfunction

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0]  = 32'h04030201;
    mem[1]  = 32'h08070605;
    mem[2]  = 32'h0C0B0A09;
    mem[5]  = 32'hA1B2C3D4;
    mem[10] = 32'h00000037;
    mem[15] = 32'hDEADBEEF;

    // Reset state
    #12;
    chkb("rst_tx", tx, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    step();
    reset = 1'b1;
    step();

    // One word at base 10; memory overwritten after its fetch
    launch(32'd10, 8'd1);
    capture(170, 1'b0, 3, 10, 32'hFFFFFFFF);
    mem[10] = 32'h00000037;
    chk("t1_addr_c1", addr_t[1], 32'd10);
    chk("t1_addr_c100", addr_t[100], 32'd10);
    chk("t1_addr_idle", addr_t[163], 32'd0);
    for (int c = 2; c <= 5; c++) chkb("t1_startbit", tx_t[c], 1'b0);
    check_byte("t1_b0", 2,   8'h37);
    check_byte("t1_b1", 42,  8'h00);
    check_byte("t1_b2", 82,  8'h00);
    check_byte("t1_b3", 122, 8'h00);
    chkb("t1_tx_c162", tx_t[162], 1'b1);
    chkb("t1_done_c162", done_t[162], 1'b1);
    chk("t1_done_cnt", 32'(count_done(1, 170)), 32'd1);
    chk("t1_busy_cnt", 32'(count_busy(1, 170)), 32'd161);
    chkb("t1_busy_c1", busy_t[1], 1'b1);
    chkb("t1_busy_c161", busy_t[161], 1'b1);
    chkb("t1_busy_c162", busy_t[162], 1'b0);

    // Three words from base 0
    launch(32'd0, 8'd3);
    capture(490, 1'b0, 0, 0, 32'h0);
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 4; j++)
        check_byte("t2_byte", 2 + 161*w + 40*j, 8'(4*w + j + 1));
    chk("t2_addr_w0", addr_t[1], 32'd0);
    chk("t2_addr_w1", addr_t[162], 32'd1);
    chk("t2_addr_w2", addr_t[323], 32'd2);
    chkb("t2_fetch_tx1", tx_t[162], 1'b1);
    chkb("t2_fetch_tx2", tx_t[323], 1'b1);
    chkb("t2_start_after_fetch", tx_t[163], 1'b0);
    chkb("t2_done_c484", done_t[484], 1'b1);
    chk("t2_done_cnt", 32'(count_done(1, 490)), 32'd1);

    // Zero-length dump
    launch(32'd0, 8'd0);
    capture(6, 1'b0, 0, 0, 32'h0);
    chkb("t3_done_c1", done_t[1], 1'b1);
    chk("t3_done_cnt", 32'(count_done(1, 6)), 32'd1);
    chk("t3_busy_cnt", 32'(count_busy(1, 6)), 32'd0);
    chk("t3_txlow_cnt", 32'(count_txlow(1, 6)), 32'd0);

    // Start pulses while busy are ignored
    launch(32'd0, 8'd2);
    capture(400, 1'b1, 0, 0, 32'h0);
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < 4; j++)
        check_byte("t4_byte", 2 + 161*w + 40*j, 8'(4*w + j + 1));
    chkb("t4_done_c323", done_t[323], 1'b1);
    chk("t4_done_cnt", 32'(count_done(1, 400)), 32'd1);
    chk("t4_txlow_after", 32'(count_txlow(323, 400)), 32'd0);

    // Asynchronous reset in the middle of the data bits, then a fresh dump
    launch(32'd0, 8'd1);
    capture(29, 1'b0, 0, 0, 32'h0);
    chkb("t5_pre_tx", tx, 1'b0);
    chkb("t5_pre_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chkb("t5_rst_tx", tx, 1'b1);
    chkb("t5_rst_busy", busy, 1'b0);
    chkb("t5_rst_done", done, 1'b0);
    chk("t5_rst_addr", mem_addr, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();
    launch(32'd5, 8'd1);
    capture(170, 1'b0, 0, 0, 32'h0);
    chk("t5_addr_c1", addr_t[1], 32'd5);
    check_byte("t5_b0", 2,   8'hD4);
    check_byte("t5_b1", 42,  8'hC3);
    check_byte("t5_b2", 82,  8'hB2);
    check_byte("t5_b3", 122, 8'hA1);
    chkb("t5_done_c162", done_t[162], 1'b1);

    // Address wraps past 0xFFFFFFFF
    launch(32'hFFFFFFFF, 8'd2);
    capture(330, 1'b0, 0, 0, 32'h0);
    chk("t6_addr_w0", addr_t[1], 32'hFFFFFFFF);
    chk("t6_addr_w1", addr_t[162], 32'h00000000);
    check_byte("t6_b0", 2,   8'hEF);
    check_byte("t6_b1", 42,  8'hBE);
    check_byte("t6_b2", 82,  8'hAD);
    check_byte("t6_b3", 122, 8'hDE);
    check_byte("t6_b4", 163, 8'h01);
    check_byte("t6_b5", 203, 8'h02);
    check_byte("t6_b6", 243, 8'h03);
    check_byte("t6_b7", 283, 8'h04);
    chkb("t6_done_c323", done_t[323], 1'b1);
    chk("t6_done_cnt", 32'(count_done(1, 330)), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_dump_tx.md
Name: dmem_dump_tx

Overview:
- Read-side companion to the core's data memory. The single-cycle core writes results into data memory; this block reads them back out.
- On a start pulse it reads a contiguous range of data-memory words through a dedicated combinational read port.
- Each word is sent off-chip as a UART 8N1 serial stream, so the board/bench can capture program results (e.g. Fibonacci output) without probing internal memory.
- Sits beside the data memory, on a second read port, outside the core datapath.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1 to 65535.
- CNT_W, 8, width of the word-count input.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled in IDLE only.
- base_addr  input  32  first word index to read. Word addressing, same as the core's data memory.
- word_count  input  CNT_W  number of words to send; 0 is legal.
- mem_addr  output  32  read address to the data-memory read port.
- mem_rdata  input  32  combinational read data for mem_addr, valid in the same cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (asynchronous, active-low): immediately forces the following, regardless of state (including mid-frame).
  - state=IDLE, tx=1, busy=0, done=0, mem_addr=0.
  - All counters and shift registers cleared.
- States: IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE:
  - tx=1.
  - On start=1, latch base_addr into addr_reg and word_count into remaining.
  - If word_count==0, go to FINISH; else go to FETCH.
  - start in any other state is ignored (no queueing).
- FETCH (exactly 1 cycle, tx=1):
  - mem_addr=addr_reg; capture mem_rdata into word_reg.
  - byte_idx=0; go to START_BIT.
- START_BIT:
  - tx=0 for CLKS_PER_BIT cycles.
  - Load shift register with word_reg byte byte_idx: byte 0 = bits[7:0], then [15:8], [23:16], [31:24].
- DATA_BITS:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit counter 0..7.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles, then:
  - If byte_idx<3: byte_idx+1, go to START_BIT (no idle gap between bytes of a word).
  - Else: remaining-1 and addr_reg+1. If the result remaining==0, go to FINISH; else go to FETCH (one idle-high cycle between words).
- FINISH:
  - done=1 for exactly one cycle; busy=0 in this cycle.
  - Next state IDLE.
- mem_addr: equals addr_reg in every non-IDLE state; 0 in IDLE.
- addr_reg wraps modulo 2^32 (0xFFFFFFFF+1 = 0); no error.
- Memory data is sampled only in FETCH. Writes to a word after its FETCH do not affect the bytes in flight.
- Timing, start accepted at edge 0:
  - FETCH in cycle 1.
  - tx falls at cycle 2.
  - Each word occupies 40*CLKS_PER_BIT cycles of tx time, plus 1 FETCH cycle.
  - done is in the cycle after the final stop bit ends.
- busy timing: start edge to done = 1 + N*(1+40*CLKS_PER_BIT) cycles for N>0; 1 cycle for N=0.
- Bit timing counter: counts 0..CLKS_PER_BIT-1 and advances the bit at terminal count. No fractional timing.

Test Plan:
- CLKS_PER_BIT=4, mem[10]=0x00000037, base=10, count=1, start pulse at cycle 0 -> mem_addr=10 in cycle 1; tx=0 on cycles 2-5; bit stream decodes to bytes 0x37,0x00,0x00,0x00; tx high from cycle 162; done=1 only in cycle 162; busy high cycles 1-161.
- count=3, base=0, mem[0..2]=0x04030201, 0x08070605, 0x0C0B0A09 -> decoded bytes 01..0C in order; exactly one high FETCH cycle between words; mem_addr steps 0,1,2; single done pulse at cycle 484.
- count=0, start at cycle 0 -> tx stays 1 throughout; done=1 in cycle 1 only; busy never high.
- Assert start repeatedly while busy during a count=2 dump -> ignored; exactly 8 bytes sent; one done pulse.
- Reset low at cycle 30 of a dump (mid DATA_BITS) -> tx=1, busy=0, done=0, mem_addr=0 immediately (asynchronous). After release, a new start with base=5, count=1 sends mem[5] correctly.
- base=0xFFFFFFFF, count=2 -> mem_addr 0xFFFFFFFF, then 0x00000000; both words transmitted.
